clk_switch_ctrl: RTL and testbench
==================================

# clk_switch_ctrl

Control sequencer that drives the `select` input of the glitch-free clock mux (the `clk0`/`clk1` switch). It runs on the always-on `clk1` domain and monitors `clk0` for activity. It accepts switch requests over a valid/ready handshake, holds off completion until the mux handover has settled, and, when enabled, forces an automatic failover to `clk1` if `clk0` stops toggling. Its `select` output connects directly to the mux; the mux's internal two-flop handshake is covered by `SETTLE_CYC`.

## Interface
Parameters:
- `WDOG_CYC`, default 16: number of `clk1` cycles without an observed `clk0` edge before `clk0` is declared dead. Legal range ≥4.
- `SETTLE_CYC`, default 8: number of `clk1` cycles spent in SWITCH after `select` changes, before `done` is pulsed. Must be ≥4, which covers the mux's 2-stage handover on the slower clock.
- `OK_EDGES`, default 4: number of consecutive `clk0` toggle edges, each with no timeout in between, required before `clk_ok` goes high.

Ports:
- `clk1`, in, 1: block clock (always-on reference).
- `rst_n`, in, 1: reset, asynchronous, active-low; clock `clk1`.
- `clk0`, in, 1: monitored clock. It is used only by the toggle flop.
- `req_valid`, in, 1: switch request valid.
- `req_sel`, in, 1: requested source; 1 = `clk1`, 0 = `clk0`.
- `req_ready`, out, 1: high only in IDLE.
- `select`, out, 1: registered mux select; 1 = `clk1`.
- `busy`, out, 1: high in CHECK, SWITCH and DONE.
- `done`, out, 1: one-cycle pulse when an accepted request completes.
- `err`, out, 1: one-cycle pulse when a request to `clk0` is rejected.
- `clk_ok`, out, 1: `clk0` is alive.
- `failover`, out, 1: sticky flag, set by an automatic failover.
- `fail_clr`, in, 1: synchronous clear of `failover`.

## Operation
Clock monitor:
- `t0` toggles on every `clk0` posedge. It is reset to 0 by `rst_n`.
- `t0` passes through a 2-flop synchronizer, then an edge flop. `edge = s2 ^ s3`.
- A watchdog counter, `$clog2(WDOG_CYC+1)` bits wide, clears on `edge` and otherwise increments, saturating at `WDOG_CYC`.
- When the counter reaches `WDOG_CYC`, `clk_ok` goes to 0 and the edge counter clears.
- The edge counter increments on `edge`. When it reaches `OK_EDGES`, `clk_ok` goes to 1.

FSM states: IDLE, CHECK, SWITCH, DONE.
- **IDLE:** `req_ready`=1. On `req_valid`, the request is accepted and latched, and the FSM goes to CHECK.
- **CHECK** (one cycle):
  - If `req_sel` == `select`: go to DONE with no `select` change.
  - Else if `req_sel`=0 and `clk_ok`=0: pulse `err` and return to IDLE.
  - Else: toggle `select`, clear the settle counter, and go to SWITCH.
- **SWITCH:** the settle counter runs 0..`SETTLE_CYC`-1, then the FSM goes to DONE.
- **DONE:** `done`=1 for this single cycle, then the FSM returns to IDLE.

Failover (`CLK0_FAILOVER_EN` only):
- Triggered when `select`=0 and `clk_ok` falls.
- Next edge: `select`=1 and `failover`=1.
- If the FSM is not in IDLE, it aborts into SWITCH with the settle counter cleared. No `err` is raised. `done` is pulsed when the settle completes.
- Failover has priority over CHECK in the same cycle.

Flag clearing:
- `fail_clr` clears `failover` on the next edge.
- If `fail_clr` and a failover occur in the same cycle, set wins.

Reset values: state IDLE, `select`=1, `busy`=0, `done`=0, `err`=0, `clk_ok`=0, `failover`=0, all counters 0, `req_ready`=1.

## Timing
- `req_valid` and `req_ready` are sampled at edge N. CHECK is during N..N+1.
- A real switch:
  - `select` changes at edge N+1.
  - SWITCH lasts `SETTLE_CYC` cycles.
  - `done` is high during cycle N+2+`SETTLE_CYC`.
  - `req_ready` is high again at N+3+`SETTLE_CYC`.
- A no-op request pulses `done` at N+2.
- A rejected request pulses `err` at N+1 and sets `req_ready` at N+2.
- `clk0` stall detection latency is at most `WDOG_CYC`+3 `clk1` cycles (sync + edge + count). `select` goes to 1 one cycle after `clk_ok` falls.
- `req_valid` is ignored while `req_ready`=0; a request is never queued.
- Asserting `rst_n` mid-switch returns every output to its reset value asynchronously, with `select`=1.

## Configuration
- `CLK0_FAILOVER_EN` defined: automatic failover as described above.
- `CLK0_FAILOVER_EN` undefined:
  - `clk_ok` is still generated.
  - `select` changes only through accepted requests.
  - `failover` is tied to 0 and `fail_clr` is ignored.
  - The CHECK rejection rule still applies.

## Test plan
- **Reset:** release with `clk0` running at `clk1`/3 → `select`=1 and `clk_ok`=0 initially; `clk_ok`=1 after 4 synchronized edges.
- **Switch to clk0:** request `req_sel`=0 with `clk_ok`=1, defaults → `select`=0 at N+1, `done` pulse at N+10, `busy` high N+1..N+10.
- **Dead clk0 request:** stop `clk0`, wait 20 cycles, request `req_sel`=0 → `err` at N+1, `select` stays 1, no `done`.
- **No-op request:** `req_sel`=1 while `select`=1 → `done` at N+2, `select` never toggles.
- **Failover (macro on):** `select`=0, stop `clk0` → `clk_ok` falls within 19 cycles, `select`=1 the next cycle, `failover`=1. `fail_clr` then clears `failover`.
- **Failover mid-switch and reset abort:** `clk0` dies during SWITCH → SWITCH restarts and `done` is pulsed after 8 cycles. Separately, asserting `rst_n` during SWITCH → all outputs return to their reset values immediately.

Source files
------------

// File: rtl/clk_switch_ctrl.sv
// Sequencer driving the select of the glitch-free clk0/clk1 mux, with a clk0 activity monitor.
// Define CLK0_FAILOVER_EN to force select to clk1 automatically when clk0 stops toggling.
module clk_switch_ctrl #(
    parameter int WDOG_CYC   = 16,
    parameter int SETTLE_CYC = 8,
    parameter int OK_EDGES   = 4
) (
    input  logic clk1,
    input  logic rst_n,
    input  logic clk0,
    input  logic req_valid,
    input  logic req_sel,
    output logic req_ready,
    output logic select,
    output logic busy,
    output logic done,
    output logic err,
    output logic clk_ok,
    output logic failover,
    input  logic fail_clr
);

    localparam int WDOG_W   = $clog2(WDOG_CYC + 1);
    localparam int SETTLE_W = $clog2(SETTLE_CYC);
    localparam int EDGE_W   = $clog2(OK_EDGES + 1);

    localparam logic [WDOG_W-1:0]   WDOG_MAX    = WDOG_W'(WDOG_CYC);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYC - 1);
    localparam logic [EDGE_W-1:0]   EDGE_MAX    = EDGE_W'(OK_EDGES);
    localparam logic [EDGE_W-1:0]   EDGE_PRE    = EDGE_W'(OK_EDGES - 1);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        SWITCH,
        DONE
    } state_e;

    // clk0 domain: a single toggle flop, so only a slow level crosses into clk1.
    logic t0_q, t0_d;

    always_comb t0_d = ~t0_q;

    // NOTE: sequential state is written with non-blocking assignments only, so every
    // flop samples the pre-edge value of its neighbours regardless of process order.
    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            t0_q <= 1'b0;
        end else begin
            t0_q <= t0_d;
        end
    end

    // clk1 domain monitor: two-flop synchronizer, edge flop, watchdog and edge counter.
    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic              sync3_q, sync3_d;
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic [EDGE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic              clk_ok_q, clk_ok_d;
    logic              edge_det;
    logic              timeout;

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path leaves it
        // unassigned and no latch is inferred.
        sync1_d    = t0_q;
        sync2_d    = sync1_q;
        sync3_d    = sync2_q;
        edge_det   = sync2_q ^ sync3_q;
        timeout    = (wdog_q == WDOG_MAX);
        wdog_d     = wdog_q;
        edge_cnt_d = edge_cnt_q;
        clk_ok_d   = clk_ok_q;

        if (edge_det) begin
            wdog_d = '0;
        end else if (!timeout) begin
            wdog_d = wdog_q + 1'b1;
        end

        if (timeout) begin
            edge_cnt_d = '0;
            clk_ok_d   = 1'b0;
        end else if (edge_det && (edge_cnt_q != EDGE_MAX)) begin
            edge_cnt_d = edge_cnt_q + 1'b1;
            if (edge_cnt_q == EDGE_PRE) begin
                clk_ok_d = 1'b1;
            end
        end
    end

    // Switch sequencer.
    state_e              state_q, state_d;
    logic                req_sel_q, req_sel_d;
    logic                select_q, select_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic                failover_q, failover_d;
    logic                fo_trig;

`ifdef CLK0_FAILOVER_EN
    // Level form of "clk_ok fell while on clk0": the mux must never stay on a dead clock.
    assign fo_trig = !select_q && !clk_ok_q;
`else
    assign fo_trig = 1'b0;
`endif

    // Without the failover feature fo_trig is 0, so this flop never leaves its reset value.
    assign failover_d = fo_trig | (failover_q & ~fail_clr);

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            sync3_q    <= 1'b0;
            wdog_q     <= '0;
            edge_cnt_q <= '0;
            clk_ok_q   <= 1'b0;
            state_q    <= IDLE;
            req_sel_q  <= 1'b0;
            select_q   <= 1'b1;
            settle_q   <= '0;
            failover_q <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            sync3_q    <= sync3_d;
            wdog_q     <= wdog_d;
            edge_cnt_q <= edge_cnt_d;
            clk_ok_q   <= clk_ok_d;
            state_q    <= state_d;
            req_sel_q  <= req_sel_d;
            select_q   <= select_d;
            settle_q   <= settle_d;
            failover_q <= failover_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_sel_d = req_sel_q;
        select_d  = select_q;
        settle_d  = settle_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    req_sel_d = req_sel;
                    state_d   = CHECK;
                end
            end
            CHECK: begin
                if (req_sel_q == select_q) begin
                    state_d = DONE;
                end else if (!req_sel_q && !clk_ok_q) begin
                    state_d = IDLE;
                end else begin
                    select_d = ~select_q;
                    settle_d = '0;
                    state_d  = SWITCH;
                end
            end
            SWITCH: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d = DONE;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Failover overrides whatever the sequencer decided this cycle, CHECK included.
        if (fo_trig) begin
            select_d = 1'b1;
            if (state_q != IDLE) begin
                state_d  = SWITCH;
                settle_d = '0;
            end
        end
    end

    always_comb begin
        req_ready = (state_q == IDLE);
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
        err       = (state_q == CHECK) && !req_sel_q && select_q && !clk_ok_q;
    end

    assign select   = select_q;
    assign clk_ok   = clk_ok_q;
    assign failover = failover_q;

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Self-checking bench for clk_switch_ctrl: directed scenarios plus randomized requests
// against a cycle-trace model derived from the request/failover rules.
module tb_clk_switch_ctrl;

    localparam int WDOG_CYC   = 16;
    localparam int SETTLE_CYC = 8;
    localparam int OK_EDGES   = 4;
`ifdef CLK0_FAILOVER_EN
    localparam bit FO_EN = 1'b1;
`else
    localparam bit FO_EN = 1'b0;
`endif

    logic clk1      = 1'b0;
    logic clk0      = 1'b0;
    logic clk0_en   = 1'b1;
    logic rst_n     = 1'b0;
    logic req_valid = 1'b0;
    logic req_sel   = 1'b0;
    logic fail_clr  = 1'b0;
    logic req_ready, select, busy, done, err, clk_ok, failover;

    int vectors     = 0;
    int miscompares = 0;

    // Model state: expected select, settled clk_ok and failover flag.
    logic sel_m = 1'b1;
    logic ok_m  = 1'b0;
    logic fo_m  = 1'b0;

    clk_switch_ctrl #(
        .WDOG_CYC  (WDOG_CYC),
        .SETTLE_CYC(SETTLE_CYC),
        .OK_EDGES  (OK_EDGES)
    ) dut (
        .clk1     (clk1),
        .rst_n    (rst_n),
        .clk0     (clk0),
        .req_valid(req_valid),
        .req_sel  (req_sel),
        .req_ready(req_ready),
        .select   (select),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .clk_ok   (clk_ok),
        .failover (failover),
        .fail_clr (fail_clr)
    );

    // clk1 period 10; clk0 period 30, offset so its edges never coincide with clk1 edges.
    always #5 clk1 = ~clk1;

    initial begin
        #2;
        forever begin
            #15;
            clk0 = clk0_en ? ~clk0 : 1'b0;
        end
    end

    // {req_ready, busy, done, err, select, clk_ok, failover}
    function automatic logic [6:0] snap();
        return {req_ready, busy, done, err, select, clk_ok, failover};
    endfunction

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    // Change clk0 activity and let the monitor settle; applies the failover rule.
    task automatic settle_clk0(input logic en);
        clk0_en = en;
        repeat (40) @(posedge clk1);
        #1;
        ok_m = en;
        if (FO_EN && !en && !sel_m) begin
            sel_m = 1'b1;
            fo_m  = 1'b1;
        end
        vectors++;
        if ({select, clk_ok, failover} !== {sel_m, ok_m, fo_m}) begin
            miscompares++;
            $display("FAIL settle_clk0(en=%0b): {select,clk_ok,failover} got %b want %b",
                     en, {select, clk_ok, failover}, {sel_m, ok_m, fo_m});
        end
    endtask

    // Issue one request (caller is just after a posedge) and check the whole trace.
    // Sample k is the cycle ending at edge N+k, where N is the accepting edge.
    task automatic run_request(input logic sel, input string tag);
        bit         noop, rej, sw;
        int         last;
        logic [6:0] want;
        noop = (sel == sel_m);
        rej  = !noop && !sel && !ok_m;
        sw   = !noop && !rej;
        last = noop ? 2 : (rej ? 1 : SETTLE_CYC + 2);
        req_valid = 1'b1;
        req_sel   = sel;
        for (int k = 0; k <= last + 2; k++) begin
            @(negedge clk1);
            want = {(k == 0) || (k > last), (k >= 1) && (k <= last), (k == last) && !rej,
                    rej && (k == 1), (sw && k >= 2) ? sel : sel_m, ok_m, fo_m};
            vectors++;
            if (snap() !== want) begin
                miscompares++;
                $display("FAIL %s k=%0d: {rdy,busy,done,err,sel,ok,fo} got %b want %b",
                         tag, k, snap(), want);
            end
            @(posedge clk1);
            #1;
            // Requests raised while busy must be dropped, never queued.
            if (k >= 1 && k < last) begin
                req_valid = 1'($urandom_range(0, 1));
                req_sel   = 1'($urandom_range(0, 1));
            end else begin
                req_valid = 1'b0;
            end
        end
        if (sw) sel_m = sel;
    endtask

    // Stop clk0 and return the number of clk1 edges until clk_ok reads 0 (0 = never).
    task automatic stall_clk0(output int n);
        tick();
        clk0_en = 1'b0;
        n = 0;
        for (int i = 1; i <= 40 && n == 0; i++) begin
            tick();
            if (!clk_ok) n = i;
        end
        vectors++;
        if (n < WDOG_CYC || n > WDOG_CYC + 3) begin
            miscompares++;
            $display("FAIL stall_latency: clk_ok fell after %0d cycles, want %0d..%0d",
                     n, WDOG_CYC, WDOG_CYC + 3);
        end
        ok_m = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        rst_n   = 1'b0;
        clk0_en = 1'b1;
        repeat (3) @(posedge clk1);
        @(negedge clk1);
        vectors++;
        if (snap() !== 7'b1000100) begin
            miscompares++;
            $display("FAIL reset_hold: got %b want %b", snap(), 7'b1000100);
        end
        tick();
        rst_n = 1'b1;
        @(negedge clk1);
        vectors++;
        if (snap() !== 7'b1000100) begin
            miscompares++;
            $display("FAIL reset_release: got %b want %b", snap(), 7'b1000100);
        end
        repeat (8) @(posedge clk1);
        #1;
        vectors++;
        if (clk_ok !== 1'b0) begin
            miscompares++;
            $display("FAIL clk_ok_early: got %b want 0 before %0d edges", clk_ok, OK_EDGES);
        end
        n = 0;
        for (int i = 1; i <= 25 && n == 0; i++) begin
            tick();
            if (clk_ok === 1'b1) n = i;
        end
        vectors++;
        if (n == 0) begin
            miscompares++;
            $display("FAIL clk_ok_rise: clk_ok got 0 want 1 within 33 cycles of reset");
        end
        sel_m = 1'b1;
        ok_m  = 1'b1;
        fo_m  = 1'b0;
    endtask

    task automatic test_noop();
        tick();
        run_request(1'b1, "noop_to_clk1");
    endtask

    task automatic test_switch();
        run_request(1'b0, "switch_to_clk0");
        run_request(1'b1, "switch_to_clk1");
    endtask

    task automatic test_dead_request();
        int n;
        stall_clk0(n);
        repeat (3) tick();
        run_request(1'b0, "dead_clk0_request");
        settle_clk0(1'b1);
    endtask

    task automatic test_failover();
        int n;
        run_request(1'b0, "switch_before_stall");
        stall_clk0(n);
`ifdef CLK0_FAILOVER_EN
        vectors++;
        if ({select, failover} !== 2'b00) begin
            miscompares++;
            $display("FAIL select_at_fall: {select,failover} got %b want 00", {select, failover});
        end
        tick();
        vectors++;
        if ({select, failover, busy} !== 3'b110) begin
            miscompares++;
            $display("FAIL failover_set: {select,failover,busy} got %b want 110",
                     {select, failover, busy});
        end
        fail_clr = 1'b1;
        tick();
        fail_clr = 1'b0;
        vectors++;
        if ({select, failover} !== 2'b10) begin
            miscompares++;
            $display("FAIL fail_clr: {select,failover} got %b want 10", {select, failover});
        end
        sel_m = 1'b1;
        fo_m  = 1'b0;
`else
        repeat (5) tick();
        fail_clr = 1'b1;
        tick();
        fail_clr = 1'b0;
        tick();
        vectors++;
        if ({select, failover} !== 2'b00) begin
            miscompares++;
            $display("FAIL no_failover: {select,failover} got %b want 00", {select, failover});
        end
        run_request(1'b1, "manual_switch_dead_clk0");
`endif
        settle_clk0(1'b1);
    endtask

`ifdef CLK0_FAILOVER_EN
    task automatic test_failover_mid_switch();
        int         x, done_early, errs;
        logic       seen_zero;
        logic [6:0] want;
        tick();
        clk0_en = 1'b0;
        repeat (13) @(posedge clk1);
        #1;
        req_valid = 1'b1;
        req_sel   = 1'b0;
        tick();
        req_valid  = 1'b0;
        x          = -1;
        done_early = 0;
        errs       = 0;
        seen_zero  = 1'b0;
        for (int i = 0; i < 40 && x < 0; i++) begin
            @(negedge clk1);
            if (err) errs++;
            if (!select) seen_zero = 1'b1;
            else if (seen_zero) x = i;
            if (x < 0 && done) done_early++;
        end
        vectors++;
        if (x < 0) begin
            miscompares++;
            $display("FAIL failover_mid_switch: select got no 0->1 return want one within 40 cycles");
        end else if (!failover || !busy || done || done_early != 0 || errs != 0) begin
            miscompares++;
            $display("FAIL failover_abort: fo=%b busy=%b done=%b early_done=%0d errs=%0d want 1 1 0 0 0",
                     failover, busy, done, done_early, errs);
        end
        if (x >= 0) begin
            for (int j = 1; j <= SETTLE_CYC + 1; j++) begin
                @(negedge clk1);
                want = {j == SETTLE_CYC + 1, j <= SETTLE_CYC, j == SETTLE_CYC, 1'b0, 1'b1, 1'b0, 1'b1};
                vectors++;
                if (snap() !== want) begin
                    miscompares++;
                    $display("FAIL failover_settle j=%0d: got %b want %b", j, snap(), want);
                end
            end
        end
        tick();
        fail_clr = 1'b1;
        tick();
        fail_clr = 1'b0;
        sel_m = 1'b1;
        fo_m  = 1'b0;
        ok_m  = 1'b0;
        settle_clk0(1'b1);
    endtask
`endif

    task automatic test_reset_abort();
        tick();
        req_valid = 1'b1;
        req_sel   = 1'b0;
        tick();
        req_valid = 1'b0;
        repeat (4) @(posedge clk1);
        @(negedge clk1);
        vectors++;
        if ({select, busy} !== 2'b01) begin
            miscompares++;
            $display("FAIL pre_abort: {select,busy} got %b want 01", {select, busy});
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (snap() !== 7'b1000100) begin
            miscompares++;
            $display("FAIL reset_abort: got %b want %b", snap(), 7'b1000100);
        end
        tick();
        rst_n = 1'b1;
        sel_m = 1'b1;
        fo_m  = 1'b0;
        ok_m  = 1'b0;
        settle_clk0(1'b1);
    endtask

    task automatic test_random();
        int r;
        for (int it = 0; it < 30; it++) begin
            r = int'($urandom_range(0, 7));
            if (r == 0) begin
                settle_clk0(~clk0_en);
            end else if (r == 1) begin
                fail_clr = 1'b1;
                tick();
                fail_clr = 1'b0;
                fo_m     = 1'b0;
            end
            run_request(1'($urandom_range(0, 1)), "random_request");
            repeat ($urandom_range(0, 3)) tick();
        end
    endtask

    initial begin
        test_reset();
        test_noop();
        test_switch();
        test_dead_request();
        test_failover();
`ifdef CLK0_FAILOVER_EN
        test_failover_mid_switch();
`endif
        test_reset_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at 500 us, want finished");
        $fatal(1, "bench did not finish");
    end

endmodule
